// File: rtl/sram_vga_arbiter.sv
// rtl/sram_vga_arbiter.sv - single-port async SRAM arbiter: fixed-latency video reads, CPU byte port in free slots
// Optional build macro: ARB_STALL_CNT_EN adds O_stall_cnt, a saturating count of CPU arbitration losses.
module sram_vga_arbiter #(
  parameter int ADR_WIDTH = 19,
  parameter int DAT_WIDTH = 8
) (
  input  logic                 I_vga_clk,
  input  logic                 I_reset,
  input  logic                 I_vga_req,
  input  logic [ADR_WIDTH-1:0] I_vga_adr,
  output logic [DAT_WIDTH-1:0] O_vga_dat,
  input  logic                 I_cpu_stb,
  input  logic                 I_cpu_we,
  input  logic [ADR_WIDTH-1:0] I_cpu_adr,
  input  logic [DAT_WIDTH-1:0] I_cpu_dat,
  output logic [DAT_WIDTH-1:0] O_cpu_dat,
  output logic                 O_cpu_ack,
  output logic [ADR_WIDTH-1:0] O_sram_adr,
  output logic [DAT_WIDTH-1:0] O_sram_dat,
  output logic                 O_sram_dat_oe,
  input  logic [DAT_WIDTH-1:0] I_sram_dat,
  output logic                 O_sram_oe_n,
  output logic                 O_sram_we_n
`ifdef ARB_STALL_CNT_EN
  ,
  output logic [15:0]          O_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_VGA_RD,
    ST_CPU_RD,
    ST_CPU_WR
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic                 cpu_busy;
  logic                 cpu_grant;
  logic [DAT_WIDTH-1:0] vga_hold;

  // A CPU access may not start back-to-back with another one or on its ack edge.
  assign cpu_busy  = (state_q == ST_CPU_RD) || (state_q == ST_CPU_WR);
  assign cpu_grant = I_cpu_stb && !cpu_busy && !O_cpu_ack;

  // Next bus slot: video always wins, CPU only when the slot is free.
  always_comb begin
    state_d = ST_IDLE;
    if (I_vga_req) begin
      state_d = ST_VGA_RD;
    end else if (cpu_grant) begin
      state_d = I_cpu_we ? ST_CPU_WR : ST_CPU_RD;
    end
  end

  // State register; every bus state lasts exactly one cycle.
  always_ff @(posedge I_vga_clk) begin
    if (I_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Registered SRAM pins, decoded from the state entered at this edge.
  always_ff @(posedge I_vga_clk) begin
    if (I_reset) begin
      O_sram_adr    <= '0;
      O_sram_dat    <= '0;
      O_sram_dat_oe <= 1'b0;
      O_sram_oe_n   <= 1'b1;
      O_sram_we_n   <= 1'b1;
    end else begin
      if (I_vga_req) begin
        O_sram_adr <= I_vga_adr;
      end else if (cpu_grant) begin
        O_sram_adr <= I_cpu_adr;
        O_sram_dat <= I_cpu_dat;
      end
      O_sram_oe_n   <= !((state_d == ST_VGA_RD) || (state_d == ST_CPU_RD));
      O_sram_we_n   <= (state_d != ST_CPU_WR);
      O_sram_dat_oe <= (state_d == ST_CPU_WR);
    end
  end

  // CPU completion: one-cycle ack at the edge ending a CPU slot, read data captured with it.
  always_ff @(posedge I_vga_clk) begin
    if (I_reset) begin
      O_cpu_ack <= 1'b0;
      O_cpu_dat <= '0;
    end else begin
      O_cpu_ack <= cpu_busy;
      if (state_q == ST_CPU_RD) begin
        O_cpu_dat <= I_sram_dat;
      end
    end
  end

  // Video hold register keeps the last fetched pixel byte outside VGA_RD.
  always_ff @(posedge I_vga_clk) begin
    if (I_reset) begin
      vga_hold <= '0;
    end else if (state_q == ST_VGA_RD) begin
      vga_hold <= I_sram_dat;
    end
  end

  assign O_vga_dat = (state_q == ST_VGA_RD) ? I_sram_dat : vga_hold;

`ifdef ARB_STALL_CNT_EN
  // Count edges where a pending CPU access lost the slot to video, saturating.
  always_ff @(posedge I_vga_clk) begin
    if (I_reset) begin
      O_stall_cnt <= 16'd0;
    end else if (I_vga_req && I_cpu_stb && !cpu_busy && !O_cpu_ack && (O_stall_cnt != 16'hFFFF)) begin
      O_stall_cnt <= O_stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sram_vga_arbiter.sv
// tb/tb_sram_vga_arbiter.sv - randomized self-checking bench for sram_vga_arbiter with SRAM and reference models
module tb_sram_vga_arbiter;

  localparam int AW = 19;
  localparam int DW = 8;
  localparam int MEM_SIZE = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          vga_req = 1'b0;
  logic [AW-1:0] vga_adr = '0;
  logic [DW-1:0] vga_dat;
  logic          cpu_stb = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_adr = '0;
  logic [DW-1:0] cpu_wdat = '0;
  logic [DW-1:0] cpu_rdat;
  logic          cpu_ack;
  logic [AW-1:0] sram_adr;
  logic [DW-1:0] sram_dout;
  logic          sram_dat_oe;
  logic [DW-1:0] sram_din;
  logic          sram_oe_n;
  logic          sram_we_n;
`ifdef ARB_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] sram    [MEM_SIZE];
  logic [DW-1:0] ref_mem [MEM_SIZE];

  // Reference model: which kind of slot the bus is in (0 idle, 1 video, 2 cpu read, 3 cpu write).
  int            m_kind = 0;
  logic [AW-1:0] m_adr = '0;
  logic [DW-1:0] m_dat = '0;
  logic          m_ack = 1'b0;
  logic [DW-1:0] m_cpu_dat = '0;
  logic [DW-1:0] m_hold = '0;
  logic [15:0]   m_stall = '0;
  logic          m_free;

  always #5 clk = ~clk;

  sram_vga_arbiter #(.ADR_WIDTH(AW), .DAT_WIDTH(DW)) dut (
    .I_vga_clk     (clk),
    .I_reset       (rst),
    .I_vga_req     (vga_req),
    .I_vga_adr     (vga_adr),
    .O_vga_dat     (vga_dat),
    .I_cpu_stb     (cpu_stb),
    .I_cpu_we      (cpu_we),
    .I_cpu_adr     (cpu_adr),
    .I_cpu_dat     (cpu_wdat),
    .O_cpu_dat     (cpu_rdat),
    .O_cpu_ack     (cpu_ack),
    .O_sram_adr    (sram_adr),
    .O_sram_dat    (sram_dout),
    .O_sram_dat_oe (sram_dat_oe),
    .I_sram_dat    (sram_din),
    .O_sram_oe_n   (sram_oe_n),
    .O_sram_we_n   (sram_we_n)
`ifdef ARB_STALL_CNT_EN
    ,
    .O_stall_cnt   (stall_cnt)
`endif
  );

  // Asynchronous SRAM: drives data while oe_n is low, bus floats to 0xEE otherwise.
  assign sram_din = sram_oe_n ? 8'hEE : sram[sram_adr];

  always @(posedge clk) begin
    if (!sram_we_n && sram_dat_oe) sram[sram_adr] = sram_dout;
  end

  // Transaction-level reference of the arbitration rules.
  always @(posedge clk) begin
    if (m_kind == 3) ref_mem[m_adr] = m_dat;
    if (rst) begin
      m_kind = 0; m_adr = '0; m_dat = '0; m_ack = 1'b0;
      m_cpu_dat = '0; m_hold = '0; m_stall = '0;
    end else begin
      m_free = (m_kind < 2) && !m_ack;
      m_ack = (m_kind >= 2);
      if (m_kind == 2) m_cpu_dat = ref_mem[m_adr];
      if (m_kind == 1) m_hold = ref_mem[m_adr];
      if (vga_req) begin
        if (cpu_stb && m_free && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
        m_kind = 1;
        m_adr = vga_adr;
      end else if (cpu_stb && m_free) begin
        m_kind = cpu_we ? 3 : 2;
        m_adr = cpu_adr;
        m_dat = cpu_wdat;
      end else begin
        m_kind = 0;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1; vga_req = 1'b0; cpu_stb = 1'b0; cpu_we = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; vga_req = 1'b1; cpu_stb = 1'b1;
    @(negedge clk);
    n_checks++; if (sram_oe_n !== 1'b1) begin n_errors++; $display("FAIL reset_oe_n got %b exp 1", sram_oe_n); end
    n_checks++; if (sram_we_n !== 1'b1) begin n_errors++; $display("FAIL reset_we_n got %b exp 1", sram_we_n); end
    n_checks++; if (sram_dat_oe !== 1'b0) begin n_errors++; $display("FAIL reset_dat_oe got %b exp 0", sram_dat_oe); end
    n_checks++; if (sram_adr !== 19'h0) begin n_errors++; $display("FAIL reset_adr got %h exp 0", sram_adr); end
    n_checks++; if (sram_dout !== 8'h00) begin n_errors++; $display("FAIL reset_sram_dat got %h exp 0", sram_dout); end
    n_checks++; if (cpu_ack !== 1'b0) begin n_errors++; $display("FAIL reset_ack got %b exp 0", cpu_ack); end
    n_checks++; if (cpu_rdat !== 8'h00) begin n_errors++; $display("FAIL reset_cpu_dat got %h exp 0", cpu_rdat); end
    n_checks++; if (vga_dat !== 8'h00) begin n_errors++; $display("FAIL reset_vga_dat got %h exp 0", vga_dat); end
    rst = 1'b0; vga_req = 1'b0; cpu_stb = 1'b0;
  endtask

  task automatic test_vga_read();
    do_reset();
    sram[19'h20000] = 8'hA5; ref_mem[19'h20000] = 8'hA5;
    vga_req = 1'b1; vga_adr = 19'h20000;
    @(negedge clk);
    vga_req = 1'b0;
    n_checks++; if (sram_adr !== 19'h20000) begin n_errors++; $display("FAIL vga_adr got %h exp 20000", sram_adr); end
    n_checks++; if (sram_oe_n !== 1'b0) begin n_errors++; $display("FAIL vga_oe_n got %b exp 0", sram_oe_n); end
    n_checks++; if (vga_dat !== 8'hA5) begin n_errors++; $display("FAIL vga_dat_live got %h exp a5", vga_dat); end
    @(negedge clk);
    n_checks++; if (sram_oe_n !== 1'b1) begin n_errors++; $display("FAIL vga_oe_n_after got %b exp 1", sram_oe_n); end
    n_checks++; if (vga_dat !== 8'hA5) begin n_errors++; $display("FAIL vga_dat_held got %h exp a5", vga_dat); end
    n_checks++; if (sram_adr !== 19'h20000) begin n_errors++; $display("FAIL vga_adr_hold got %h exp 20000", sram_adr); end
  endtask

  task automatic test_cpu_write_read();
    do_reset();
    cpu_stb = 1'b1; cpu_we = 1'b1; cpu_adr = 19'h00010; cpu_wdat = 8'h3C;
    @(negedge clk);
    n_checks++; if (sram_we_n !== 1'b0) begin n_errors++; $display("FAIL wr_we_n got %b exp 0", sram_we_n); end
    n_checks++; if (sram_dat_oe !== 1'b1) begin n_errors++; $display("FAIL wr_dat_oe got %b exp 1", sram_dat_oe); end
    n_checks++; if (sram_dout !== 8'h3C) begin n_errors++; $display("FAIL wr_sram_dat got %h exp 3c", sram_dout); end
    n_checks++; if (cpu_ack !== 1'b0) begin n_errors++; $display("FAIL wr_early_ack got %b exp 0", cpu_ack); end
    @(negedge clk);
    n_checks++; if (cpu_ack !== 1'b1) begin n_errors++; $display("FAIL wr_ack got %b exp 1", cpu_ack); end
    n_checks++; if (sram_we_n !== 1'b1) begin n_errors++; $display("FAIL wr_we_n_end got %b exp 1", sram_we_n); end
    @(negedge clk);
    cpu_stb = 1'b0;
    n_checks++; if (cpu_ack !== 1'b0) begin n_errors++; $display("FAIL wr_ack_absorb got %b exp 0", cpu_ack); end
    n_checks++; if (sram_we_n !== 1'b1) begin n_errors++; $display("FAIL wr_no_restart got %b exp 1", sram_we_n); end
    cpu_stb = 1'b1; cpu_we = 1'b0;
    @(negedge clk);
    n_checks++; if (sram_oe_n !== 1'b0) begin n_errors++; $display("FAIL rd_oe_n got %b exp 0", sram_oe_n); end
    @(negedge clk);
    n_checks++; if (cpu_ack !== 1'b1) begin n_errors++; $display("FAIL rd_ack got %b exp 1", cpu_ack); end
    n_checks++; if (cpu_rdat !== 8'h3C) begin n_errors++; $display("FAIL rd_dat got %h exp 3c", cpu_rdat); end
    @(negedge clk);
    cpu_stb = 1'b0;
  endtask

  task automatic test_collision();
    logic [DW-1:0] exp_rd;
    do_reset();
    exp_rd = ref_mem[19'h00123];
    vga_req = 1'b1; vga_adr = 19'h4ABCD;
    cpu_stb = 1'b1; cpu_we = 1'b0; cpu_adr = 19'h00123;
    @(negedge clk);
    vga_req = 1'b0;
    n_checks++; if (sram_adr !== 19'h4ABCD) begin n_errors++; $display("FAIL col_vga_first got %h exp 4abcd", sram_adr); end
    @(negedge clk);
    n_checks++; if (sram_adr !== 19'h00123 || sram_oe_n !== 1'b0) begin n_errors++; $display("FAIL col_cpu_next got adr %h oe_n %b exp 00123/0", sram_adr, sram_oe_n); end
    n_checks++; if (cpu_ack !== 1'b0) begin n_errors++; $display("FAIL col_early_ack got %b exp 0", cpu_ack); end
    @(negedge clk);
    n_checks++; if (cpu_ack !== 1'b1 || cpu_rdat !== exp_rd) begin n_errors++; $display("FAIL col_ack got ack %b dat %h exp 1/%h", cpu_ack, cpu_rdat, exp_rd); end
`ifdef ARB_STALL_CNT_EN
    n_checks++; if (stall_cnt !== 16'd1) begin n_errors++; $display("FAIL col_stall got %0d exp 1", stall_cnt); end
`endif
    @(negedge clk);
    cpu_stb = 1'b0;
  endtask

  task automatic test_alternating();
    logic [DW-1:0] exp_vga;
    int acks = 0;
    logic seen_ack = 1'b0;
    do_reset();
    for (int cyc = 0; cyc < 640; cyc++) begin
      vga_req = (cyc % 2 == 0);
      vga_adr = AW'($urandom);
      if (seen_ack) begin cpu_stb = 1'b0; seen_ack = 1'b0; end
      else if (m_ack) seen_ack = 1'b1;
      else if (!cpu_stb) begin cpu_stb = 1'b1; cpu_we = 1'b0; cpu_adr = AW'($urandom_range(0, 31)); end
      @(negedge clk);
      exp_vga = (m_kind == 1) ? ref_mem[m_adr] : m_hold;
      if (cpu_ack) acks++;
      n_checks++; if (vga_dat !== exp_vga) begin n_errors++; $display("FAIL alt_vga_dat cyc %0d got %h exp %h", cyc, vga_dat, exp_vga); end
      n_checks++; if (sram_adr !== m_adr) begin n_errors++; $display("FAIL alt_adr cyc %0d got %h exp %h", cyc, sram_adr, m_adr); end
      n_checks++; if (cpu_ack !== m_ack) begin n_errors++; $display("FAIL alt_ack cyc %0d got %b exp %b", cyc, cpu_ack, m_ack); end
      if (m_ack) begin
        n_checks++; if (cpu_rdat !== m_cpu_dat) begin n_errors++; $display("FAIL alt_cpu_dat cyc %0d got %h exp %h", cyc, cpu_rdat, m_cpu_dat); end
      end
    end
    vga_req = 1'b0; cpu_stb = 1'b0;
    n_checks++; if (acks < 100) begin n_errors++; $display("FAIL alt_ack_count got %0d exp >= 100", acks); end
  endtask

  task automatic test_starve();
    logic [AW-1:0] last_adr;
    logic [DW-1:0] exp_rd;
    do_reset();
    exp_rd = ref_mem[19'h00005];
    cpu_stb = 1'b1; cpu_we = 1'b0; cpu_adr = 19'h00005;
    for (int cyc = 0; cyc < 100; cyc++) begin
      vga_req = 1'b1;
      vga_adr = AW'($urandom);
      last_adr = vga_adr;
      @(negedge clk);
      n_checks++; if (cpu_ack !== 1'b0) begin n_errors++; $display("FAIL starve_ack cyc %0d got %b exp 0", cyc, cpu_ack); end
      n_checks++; if (vga_dat !== ref_mem[last_adr]) begin n_errors++; $display("FAIL starve_vga cyc %0d got %h exp %h", cyc, vga_dat, ref_mem[last_adr]); end
    end
    vga_req = 1'b0;
`ifdef ARB_STALL_CNT_EN
    n_checks++; if (stall_cnt !== 16'd100) begin n_errors++; $display("FAIL starve_stall got %0d exp 100", stall_cnt); end
`endif
    @(negedge clk);
    n_checks++; if (sram_oe_n !== 1'b0 || sram_adr !== 19'h00005) begin n_errors++; $display("FAIL starve_cpu_slot got oe_n %b adr %h exp 0/00005", sram_oe_n, sram_adr); end
    @(negedge clk);
    n_checks++; if (cpu_ack !== 1'b1 || cpu_rdat !== exp_rd) begin n_errors++; $display("FAIL starve_ack_end got %b/%h exp 1/%h", cpu_ack, cpu_rdat, exp_rd); end
    @(negedge clk);
    cpu_stb = 1'b0;
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    cpu_stb = 1'b1; cpu_we = 1'b1; cpu_adr = 19'h00077; cpu_wdat = 8'h5A;
    @(negedge clk);
    n_checks++; if (sram_we_n !== 1'b0) begin n_errors++; $display("FAIL rstw_we_n got %b exp 0", sram_we_n); end
    rst = 1'b1; cpu_stb = 1'b0;
    @(negedge clk);
    n_checks++; if (sram_we_n !== 1'b1 || sram_dat_oe !== 1'b0) begin n_errors++; $display("FAIL rstw_pins got we_n %b dat_oe %b exp 1/0", sram_we_n, sram_dat_oe); end
    n_checks++; if (cpu_ack !== 1'b0 || sram_oe_n !== 1'b1) begin n_errors++; $display("FAIL rstw_idle got ack %b oe_n %b exp 0/1", cpu_ack, sram_oe_n); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (cpu_ack !== 1'b0) begin n_errors++; $display("FAIL rstw_no_ack got %b exp 0", cpu_ack); end
  endtask

  task automatic test_random();
    logic [DW-1:0] exp_vga;
    logic seen_ack = 1'b0;
    do_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      vga_req = ($urandom_range(0, 2) == 0);
      vga_adr = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 15)) : AW'($urandom);
      if (seen_ack) begin cpu_stb = 1'b0; seen_ack = 1'b0; end
      else if (m_ack) seen_ack = 1'b1;
      else if (!cpu_stb && $urandom_range(0, 1) == 0) begin
        cpu_stb = 1'b1; cpu_we = $urandom_range(0, 1) == 1;
        cpu_adr = AW'($urandom_range(0, 15)); cpu_wdat = DW'($urandom);
      end
      @(negedge clk);
      exp_vga = (m_kind == 1) ? ref_mem[m_adr] : m_hold;
      n_checks++; if (sram_oe_n !== !(m_kind == 1 || m_kind == 2)) begin n_errors++; $display("FAIL rnd_oe_n cyc %0d got %b kind %0d", cyc, sram_oe_n, m_kind); end
      n_checks++; if (sram_we_n !== (m_kind != 3) || sram_dat_oe !== (m_kind == 3)) begin n_errors++; $display("FAIL rnd_we cyc %0d got we_n %b dat_oe %b kind %0d", cyc, sram_we_n, sram_dat_oe, m_kind); end
      n_checks++; if (sram_adr !== m_adr || sram_dout !== m_dat) begin n_errors++; $display("FAIL rnd_bus cyc %0d got %h/%h exp %h/%h", cyc, sram_adr, sram_dout, m_adr, m_dat); end
      n_checks++; if (cpu_ack !== m_ack || cpu_rdat !== m_cpu_dat) begin n_errors++; $display("FAIL rnd_cpu cyc %0d got %b/%h exp %b/%h", cyc, cpu_ack, cpu_rdat, m_ack, m_cpu_dat); end
      n_checks++; if (vga_dat !== exp_vga) begin n_errors++; $display("FAIL rnd_vga cyc %0d got %h exp %h", cyc, vga_dat, exp_vga); end
`ifdef ARB_STALL_CNT_EN
      n_checks++; if (stall_cnt !== m_stall) begin n_errors++; $display("FAIL rnd_stall cyc %0d got %0d exp %0d", cyc, stall_cnt, m_stall); end
`endif
    end
    vga_req = 1'b0; cpu_stb = 1'b0;
  endtask

  initial begin
    for (int a = 0; a < MEM_SIZE; a++) begin
      sram[a] = DW'(a * 37 + (a >> 8));
      ref_mem[a] = DW'(a * 37 + (a >> 8));
    end
    @(negedge clk);
    test_reset();
    test_vga_read();
    test_cpu_write_read();
    test_collision();
    test_alternating();
    test_starve();
    test_reset_mid_write();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
